// File: rtl/dotprod_vec_loader.sv
// Stream-to-SRAM loader for the dotprod kernel: fills SRAM A then SRAM B with n words each,
// kicks the kernel and reports done. Define LOADER_CHECKSUM_EN to add the running-sum checksum port.
module dotprod_vec_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start,
  input  logic [31:0]       n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] din_b,
  output logic              ena_a,
  output logic              ena_b,
  output logic              wea_a,
  output logic              wea_b,
  output logic              kern_start,
  input  logic              kern_finish,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef LOADER_CHECKSUM_EN
  , output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_KICK   = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic                wr_a_q, wr_a_d, wr_b_q, wr_b_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_W-1:0]   din_a_q, din_a_d, din_b_q, din_b_d;
  logic                kick_q, kick_d, done_q, done_d, err_q, err_d;
  logic                n_ok_s, last_s, hs_s, accept_s;

  assign n_ok_s   = (n != 32'd0) && (n <= 32'(DEPTH));
  assign last_s   = ((cnt_q + CNT_ONE) == n_q);
  assign s_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign busy     = (state_q != S_IDLE);
  assign hs_s     = s_ready && s_valid;
  assign accept_s = (state_q == S_IDLE) && start && n_ok_s;

  // Next-state, counter and SRAM write-port logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    wr_a_d   = 1'b0;
    wr_b_d   = 1'b0;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    din_a_d  = din_a_q;
    din_b_d  = din_b_q;
    kick_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_ok_s) begin
            n_d     = n[ADDR_W:0];
            cnt_d   = '0;
            state_d = S_LOAD_A;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_A: begin
        if (s_valid) begin
          wr_a_d   = 1'b1;
          addr_a_d = cnt_q[ADDR_W-1:0];
          din_a_d  = s_data;
          if (last_s) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_LOAD_B: begin
        if (s_valid) begin
          wr_b_d   = 1'b1;
          addr_b_d = cnt_q[ADDR_W-1:0];
          din_b_d  = s_data;
          if (last_s) begin
            cnt_d   = '0;
            state_d = S_KICK;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      // kern_start lands one cycle later, i.e. right after the last B write is visible.
      S_KICK: begin
        kick_d  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (kern_finish) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      wr_a_q   <= 1'b0;
      wr_b_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      din_a_q  <= '0;
      din_b_q  <= '0;
      kick_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      wr_a_q   <= wr_a_d;
      wr_b_q   <= wr_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      din_a_q  <= din_a_d;
      din_b_q  <= din_b_d;
      kick_q   <= kick_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign addr_a     = addr_a_q;
  assign addr_b     = addr_b_q;
  assign din_a      = din_a_q;
  assign din_b      = din_b_q;
  assign ena_a      = wr_a_q;
  assign wea_a      = wr_a_q;
  assign ena_b      = wr_b_q;
  assign wea_b      = wr_b_q;
  assign kern_start = kick_q;
  assign done       = done_q;
  assign err        = err_q;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  // Running sum of accepted words, restarted by every accepted start.
  always_comb begin
    sum_d = sum_q;
    if (accept_s) begin
      sum_d = '0;
    end else if (hs_s) begin
      sum_d = sum_q + s_data;
    end else begin
      sum_d = sum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`endif

endmodule
